// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit-path constants, FIFO status masks and TX FSM encoding
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // FIFO status word bit masks
    localparam logic [3:0] FIFO_EMPTY  = 4'd1;
    localparam logic [3:0] FIFO_FULL   = 4'd2;
    localparam logic [3:0] FIFO_AFULL  = 4'd4;
    localparam logic [3:0] FIFO_AEMPTY = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - FIFO-side and line-side signals of the UART transmit serializer
interface uart_tx_serializer_if
    import uart_pkg::*;
();

    logic                      Enable;
    logic                      Fifo_Empty;
    logic [UART_DATA_BITS-1:0] Fifo_Data;
    logic                      Fifo_Read;
    logic                      Tx;
    logic                      Busy;
    logic                      Tx_Done;

    modport master (
        output Enable, Fifo_Empty, Fifo_Data,
        input  Fifo_Read, Tx, Busy, Tx_Done
    );

    modport slave (
        input  Enable, Fifo_Empty, Fifo_Data,
        output Fifo_Read, Tx, Busy, Tx_Done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with synchronous clear and terminal-count pulse
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tc_o
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = !clear_i && (cnt_q == LAST);

    // Terminal count wraps straight to zero so consecutive bits share no dead cycle.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - pops bytes from the TX FIFO and serializes them as UART frames
// Optional parity bit after the data bits when UART_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input logic                 Clk,
    input logic                 Reset,
    uart_tx_serializer_if.slave bus
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic                      fifo_read_q;
    logic                      busy_q;
    logic                      tx_done_q, tx_done_d;
    logic                      bit_tc;
    logic                      timer_clear;
    logic                      start_frame;
`ifdef UART_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign timer_clear = (state_q == S_IDLE) || (state_q == S_READ) || (state_q == S_LOAD);
    assign start_frame = bus.Enable && !bus.Fifo_Empty;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clear_i (timer_clear),
        .tc_o    (bit_tc)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_done_d = 1'b0;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_frame) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = bus.Fifo_Data;
`ifdef UART_PARITY_EN
                parity_d = (^bus.Fifo_Data) ^ (PARITY_ODD != 0);
`endif
                state_d = S_START;
            end
            S_START: begin
                if (bit_tc) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tc) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_tc) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // bit_idx_q doubles as the stop-bit counter here.
                if (bit_tc) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = 3'd0;
                        tx_done_d = 1'b1;
                        state_d   = start_frame ? S_READ : S_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so Tx never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= 3'd0;
            tx_q        <= 1'b1;
            fifo_read_q <= 1'b0;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            fifo_read_q <= (state_d == S_READ);
            busy_q      <= (state_d != S_IDLE);
            tx_done_q   <= tx_done_d;
`ifdef UART_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.Tx        = tx_q;
    assign bus.Fifo_Read = fifo_read_q;
    assign bus.Busy      = busy_q;
    assign bus.Tx_Done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4, STOP_BITS=1)
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    int         n_cmp;
    int         n_err;

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [7:0] fifo_data;

    uart_tx_serializer_if bus ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1),
        .PARITY_ODD   (0)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

`ifdef UART_PARITY_EN
    uart_tx_serializer_if bus_o ();

    assign bus_o.Enable     = bus.Enable;
    assign bus_o.Fifo_Empty = bus.Fifo_Empty;
    assign bus_o.Fifo_Data  = bus.Fifo_Data;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1),
        .PARITY_ODD   (1)
    ) dut_odd (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_o.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read data appears in the cycle after the pop request.
    assign bus.Fifo_Empty = (wr_ptr == rd_ptr);
    assign bus.Fifo_Data  = fifo_data;

    always @(posedge clk) begin
        if (bus.Fifo_Read && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic wait_read(input string tag);
        int k;
        k = 0;
        tick();
        while (bus.Fifo_Read !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_cmp++;
        if (bus.Fifo_Read !== 1'b1) begin
            n_err++;
            $display("FAIL %s_pop: Fifo_Read=%b required 1", tag, bus.Fifo_Read);
        end
    endtask

    // Entered on the first START cycle; leaves on the cycle after the last stop cycle.
    task automatic expect_frame(input logic [7:0] d, input logic par, input string tag);
        logic [11:0] bits;
        int          nb;
`ifdef UART_PARITY_EN
        bits = {1'b0, 1'b1, par, d, 1'b0};
        nb   = 11;
`else
        bits = {2'b00, 1'b1, d, 1'b0};
        nb   = 10;
        if (par) bits = bits;
`endif
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < CPB; c++) begin
                n_cmp++;
                if ({bus.Tx, bus.Busy, bus.Fifo_Read} !== {bits[i], 1'b1, 1'b0}) begin
                    n_err++;
                    $display("FAIL %s_bit%0d_cyc%0d: Tx/Busy/Fifo_Read=%b%b%b required %b10",
                             tag, i, c, bus.Tx, bus.Busy, bus.Fifo_Read, bits[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.Enable = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.Tx, bus.Busy, bus.Fifo_Read, bus.Tx_Done} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_state: Tx/Busy/Fifo_Read/Tx_Done=%b%b%b%b required 1000",
                     bus.Tx, bus.Busy, bus.Fifo_Read, bus.Tx_Done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        bus.Enable = 1'b1;
        push(8'hA5);
        wait_read("single");
        tick();
        n_cmp++;
        if ({bus.Tx, bus.Fifo_Read} !== 2'b10) begin
            n_err++;
            $display("FAIL single_load: Tx/Fifo_Read=%b%b required 10", bus.Tx, bus.Fifo_Read);
        end
        tick();
        expect_frame(8'hA5, 1'b0, "single");
        n_cmp++;
        if ({bus.Tx_Done, bus.Busy, bus.Fifo_Read, bus.Tx} !== 4'b1001) begin
            n_err++;
            $display("FAIL single_done: Tx_Done/Busy/Fifo_Read/Tx=%b%b%b%b required 1001",
                     bus.Tx_Done, bus.Busy, bus.Fifo_Read, bus.Tx);
        end
        tick();
        n_cmp++;
        if (bus.Tx_Done !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_pulse: Tx_Done=%b required 0", bus.Tx_Done);
        end
    endtask

    task automatic test_back_to_back();
        push(8'h00);
        push(8'hFF);
        wait_read("b2b_first");
        tick();
        tick();
        expect_frame(8'h00, 1'b0, "b2b_first");
        n_cmp++;
        if ({bus.Fifo_Read, bus.Tx_Done, bus.Tx, bus.Busy} !== 4'b1111) begin
            n_err++;
            $display("FAIL b2b_read: Fifo_Read/Tx_Done/Tx/Busy=%b%b%b%b required 1111",
                     bus.Fifo_Read, bus.Tx_Done, bus.Tx, bus.Busy);
        end
        tick();
        n_cmp++;
        if ({bus.Fifo_Read, bus.Tx, bus.Busy} !== 3'b011) begin
            n_err++;
            $display("FAIL b2b_load: Fifo_Read/Tx/Busy=%b%b%b required 011",
                     bus.Fifo_Read, bus.Tx, bus.Busy);
        end
        tick();
        expect_frame(8'hFF, 1'b0, "b2b_second");
        n_cmp++;
        if ({bus.Tx_Done, bus.Busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_done: Tx_Done/Busy=%b%b required 10", bus.Tx_Done, bus.Busy);
        end
        tick();
    endtask

    task automatic test_empty_idle();
        bus.Enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n_cmp++;
            if ({bus.Fifo_Read, bus.Tx, bus.Busy} !== 3'b010) begin
                n_err++;
                $display("FAIL empty_idle_cyc%0d: Fifo_Read/Tx/Busy=%b%b%b required 010",
                         i, bus.Fifo_Read, bus.Tx, bus.Busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        push(8'h3C);
        wait_read("rstmid");
        tick();
        tick();
        for (int i = 0; i < 4 * CPB + 1; i++) tick();
        n_cmp++;
        if ({bus.Tx, bus.Busy} !== 2'b11) begin
            n_err++;
            $display("FAIL rstmid_bit3: Tx/Busy=%b%b required 11", bus.Tx, bus.Busy);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.Tx, bus.Busy, bus.Fifo_Read, bus.Tx_Done} !== 4'b1000) begin
            n_err++;
            $display("FAIL rstmid_after: Tx/Busy/Fifo_Read/Tx_Done=%b%b%b%b required 1000",
                     bus.Tx, bus.Busy, bus.Fifo_Read, bus.Tx_Done);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({bus.Fifo_Read, bus.Tx} !== 2'b01) begin
                n_err++;
                $display("FAIL rstmid_quiet_cyc%0d: Fifo_Read/Tx=%b%b required 01",
                         i, bus.Fifo_Read, bus.Tx);
            end
        end
        push(8'h81);
        wait_read("rstmid_recover");
        tick();
        tick();
        expect_frame(8'h81, 1'b0, "rstmid_recover");
        n_cmp++;
        if (bus.Tx_Done !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_recover_done: Tx_Done=%b required 1", bus.Tx_Done);
        end
        tick();
    endtask

    task automatic test_enable_drop();
        push(8'h12);
        push(8'h34);
        wait_read("endrop");
        tick();
        tick();
        bus.Enable = 1'b0;
        expect_frame(8'h12, 1'b0, "endrop");
        n_cmp++;
        if ({bus.Tx_Done, bus.Busy, bus.Fifo_Read} !== 3'b100) begin
            n_err++;
            $display("FAIL endrop_done: Tx_Done/Busy/Fifo_Read=%b%b%b required 100",
                     bus.Tx_Done, bus.Busy, bus.Fifo_Read);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({bus.Fifo_Read, bus.Busy} !== 2'b00) begin
                n_err++;
                $display("FAIL endrop_quiet_cyc%0d: Fifo_Read/Busy=%b%b required 00",
                         i, bus.Fifo_Read, bus.Busy);
            end
        end
        n_cmp++;
        if (6'(wr_ptr - rd_ptr) !== 6'd1) begin
            n_err++;
            $display("FAIL endrop_pops: bytes left=%0d required 1", 6'(wr_ptr - rd_ptr));
        end
        bus.Enable = 1'b1;
        wait_read("endrop_drain");
        tick();
        tick();
        expect_frame(8'h34, 1'b1, "endrop_drain");
        n_cmp++;
        if (bus.Tx_Done !== 1'b1) begin
            n_err++;
            $display("FAIL endrop_drain_done: Tx_Done=%b required 1", bus.Tx_Done);
        end
        tick();
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [10:0] ev;
        logic [10:0] od;
        ev = {1'b1, 1'b1, 8'h07, 1'b0};
        od = {1'b1, 1'b0, 8'h07, 1'b0};
        push(8'h07);
        wait_read("parity");
        tick();
        tick();
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < CPB; c++) begin
                n_cmp++;
                if ({bus.Tx, bus_o.Tx, bus.Busy} !== {ev[i], od[i], 1'b1}) begin
                    n_err++;
                    $display("FAIL parity_bit%0d_cyc%0d: even/odd Tx,Busy=%b%b%b required %b%b1",
                             i, c, bus.Tx, bus_o.Tx, bus.Busy, ev[i], od[i]);
                end
                tick();
            end
        end
        n_cmp++;
        if ({bus.Tx_Done, bus_o.Tx_Done} !== 2'b11) begin
            n_err++;
            $display("FAIL parity_len: Tx_Done even/odd=%b%b required 11",
                     bus.Tx_Done, bus_o.Tx_Done);
        end
        tick();
    endtask
`endif

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        wr_ptr     = 6'd0;
        rd_ptr     = 6'd0;
        fifo_data  = 8'h00;
        rst        = 1'b1;
        bus.Enable = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_empty_idle();
        test_reset_mid_frame();
        test_enable_drop();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
